// File: rtl/somador_seq_nib_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding, slice width
// and the two's-complement overflow rule.
package somador_seq_nib_pkg;

   // Controller states; encodings are fixed so they stay stable in waveforms.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Width of the slice handled per clock by the shared adder.
   localparam int NIB_W = 4;

   // Signed overflow: operands agree in sign but the result sign differs.
   function automatic logic add_ovf(input logic a_msb,
                                    input logic b_msb,
                                    input logic r_msb);
      return (a_msb == b_msb) && (r_msb != a_msb);
   endfunction

endpackage

// File: rtl/somador_seq_nib_nibble_adder4.sv
// Combinational 4-bit ripple-carry adder built from four full-adder cells.
// This is the only arithmetic in the serial adder; the top time-shares it.
module nibble_adder4
   import somador_seq_nib_pkg::*;
(
   input  logic [NIB_W-1:0] a_i,
   input  logic [NIB_W-1:0] b_i,
   input  logic             cin_i,
   output logic [NIB_W-1:0] sum_o,
   output logic             cout_o
);

   // carry_s[k] is the carry into cell k; carry_s[NIB_W] leaves the nibble.
   logic [NIB_W:0] carry_s;

   assign carry_s[0] = cin_i;

   for (genvar k = 0; k < NIB_W; k++) begin : g_fa
      assign sum_o[k]     = a_i[k] ^ b_i[k] ^ carry_s[k];
      assign carry_s[k+1] = (a_i[k] & b_i[k]) | (carry_s[k] & (a_i[k] ^ b_i[k]));
   end

   assign cout_o = carry_s[NIB_W];

endmodule

// File: rtl/somador_seq_nib.sv
// Sequential WIDTH-bit adder: one nibble per clock through a shared 4-bit
// ripple adder, with a registered carry between nibbles and a start/done
// handshake. The result is assembled by shifting nibble sums in from the MSB.
module somador_seq_nib
   import somador_seq_nib_pkg::*;
#(
   parameter int WIDTH = 16
)(
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int NIB   = WIDTH / NIB_W;
   localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

   state_t             state_q;
   logic [IDX_W-1:0]   idx_q;
   logic [WIDTH-1:0]   a_sh_q;
   logic [WIDTH-1:0]   b_sh_q;
   logic               carry_q;
   logic               a_msb_q;
   logic               b_msb_q;
   logic [WIDTH-1:0]   sum_q;
   logic               cout_q;
   logic               ovf_q;
   logic               busy_q;
   logic               done_q;

   logic [NIB_W-1:0]   nib_sum_s;
   logic               nib_cout_s;
   logic [WIDTH-1:0]   a_sh_d;
   logic [WIDTH-1:0]   b_sh_d;
   logic [WIDTH-1:0]   sum_d;
   logic               last_s;

   // The current low nibble of each operand shift register feeds the adder.
   nibble_adder4 u_nib_add (
      .a_i    (a_sh_q[NIB_W-1:0]),
      .b_i    (b_sh_q[NIB_W-1:0]),
      .cin_i  (carry_q),
      .sum_o  (nib_sum_s),
      .cout_o (nib_cout_s)
   );

   // Operands move right one nibble per step; sums enter at the MSB so that
   // after NIB steps nibble 0 has arrived at the bottom of the result.
   assign a_sh_d = {{NIB_W{1'b0}}, a_sh_q[WIDTH-1:NIB_W]};
   assign b_sh_d = {{NIB_W{1'b0}}, b_sh_q[WIDTH-1:NIB_W]};
   assign sum_d  = {nib_sum_s, sum_q[WIDTH-1:NIB_W]};
   assign last_s = (idx_q == IDX_LAST);

   // Controller, nibble counter, operand/result shift registers and flags.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         carry_q <= 1'b0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               idx_q <= '0;
               if (start) begin
                  a_sh_q  <= a;
                  b_sh_q  <= b;
                  a_msb_q <= a[WIDTH-1];
                  b_msb_q <= b[WIDTH-1];
                  carry_q <= cin;
                  busy_q  <= 1'b1;
                  state_q <= ST_ADD;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            ST_ADD: begin
               a_sh_q  <= a_sh_d;
               b_sh_q  <= b_sh_d;
               sum_q   <= sum_d;
               carry_q <= nib_cout_s;
               if (last_s) begin
                  // The top nibble sum becomes result[MSB] on this edge.
                  idx_q   <= '0;
                  cout_q  <= nib_cout_s;
                  ovf_q   <= add_ovf(a_msb_q, b_msb_q, nib_sum_s[NIB_W-1]);
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  idx_q   <= idx_q + IDX_W'(1);
                  state_q <= ST_ADD;
               end
            end
            ST_DONE: begin
               idx_q   <= '0;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               idx_q   <= '0;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign sum      = sum_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_somador_seq_nib.sv
// Scoreboard bench for somador_seq_nib (WIDTH=16): stimulus pushes hand-computed
// results, a negedge monitor pops and compares on every done pulse.
module tb_somador_seq_nib;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        busy;
   logic        done;
   logic [15:0] sum;
   logic        cout;
   logic        overflow;

   typedef struct {
      logic [15:0] s;
      logic        c;
      logic        v;
      int          acc;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   bit   pend_end = 1'b0;

   somador_seq_nib #(.WIDTH(16)) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .cout     (cout),
      .overflow (overflow)
   );

   always #5 clock = ~clock;

   // Edge counter used to measure accept-to-done latency.
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compare each done pulse against the scoreboard and check that
   // the pulse lasts one cycle and busy falls right after it.
   always @(negedge clock) begin
      exp_t e;
      if (pend_end) begin
         check("done_width", {31'd0, done}, 32'd0);
         check("busy_drop",  {31'd0, busy}, 32'd0);
         pend_end = 1'b0;
      end
      if (done) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
         end else begin
            e = q.pop_front();
            check("sum",      {16'd0, sum},          {16'd0, e.s});
            check("cout",     {31'd0, cout},         {31'd0, e.c});
            check("overflow", {31'd0, overflow},     {31'd0, e.v});
            check("latency",  cyc,                   e.acc + 4);
            pend_end = 1'b1;
         end
      end
   end

   // Issue one start at the coming edge; returns the edge number of acceptance.
   task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic cv, output int acc);
      acc   = cyc + 1;
      a     = av;
      b     = bv;
      cin   = cv;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      a     = 16'hDEAD;
      b     = 16'hBEEF;
      cin   = 1'b1;
   endtask

   // Bounded wait for the block to return to idle.
   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got busy=1 after 20 cycles expected busy=0", name);
      end
      @(negedge clock);
   endtask

   task automatic run_op(input string name, input logic [15:0] av, input logic [15:0] bv,
                         input logic cv, input logic [15:0] es, input logic ec, input logic ev);
      int   acc;
      exp_t e;
      e.s = es; e.c = ec; e.v = ev; e.acc = cyc + 1;
      q.push_back(e);
      issue(av, bv, cv, acc);
      check({name, "_busy"}, {31'd0, busy}, 32'd1);
      wait_idle(name);
   endtask

   initial begin
      int acc;
      exp_t e;
      reset = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0; cin = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_busy", {31'd0, busy},     32'd0);
      check("rst_done", {31'd0, done},     32'd0);
      check("rst_sum",  {16'd0, sum},      32'd0);
      check("rst_cout", {31'd0, cout},     32'd0);
      check("rst_ovf",  {31'd0, overflow}, 32'd0);

      run_op("basic",    16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
      run_op("wrap",     16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("cin_prop", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
      run_op("pos_ovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_op("neg_ovf",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
      run_op("alt_cin",  16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0);

      // Start while busy must be ignored: one result, one done pulse.
      e.s = 16'h0002; e.c = 1'b0; e.v = 1'b0; e.acc = cyc + 1;
      q.push_back(e);
      issue(16'h0001, 16'h0001, 1'b0, acc);
      a = 16'hAAAA; b = 16'h5555; cin = 1'b0; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      wait_idle("ignore");
      repeat (3) @(negedge clock);
      check("ignore_q_empty", q.size(), 32'd0);

      // Reset mid-operation aborts with no done pulse.
      issue(16'h1111, 16'h2222, 1'b0, acc);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("abort_busy", {31'd0, busy},     32'd0);
      check("abort_sum",  {16'd0, sum},      32'd0);
      check("abort_done", {31'd0, done},     32'd0);
      check("abort_cout", {31'd0, cout},     32'd0);
      check("abort_ovf",  {31'd0, overflow}, 32'd0);
      repeat (6) @(negedge clock);

      run_op("fresh", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);
      // Result stays stable while idle.
      repeat (3) @(negedge clock);
      check("hold_sum", {16'd0, sum}, 32'h1000);

      check("final_q_empty", q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: got no completion expected finish before 100000");
      $fatal(1, "watchdog expired");
   end

endmodule
